// File: rtl/branch_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline stages and the branch/hazard controller.
// Inputs come from the pipeline; outputs steer PC selection, stall and flush.
interface branch_hazard_ctrl_if #(
  parameter int CNTW = 16
);
  logic            id_valid;
  logic [4:0]      id_opCode;
  logic            ex_flagWr;
  logic            alu_Cout;
  logic            alu_Zout;
  logic            pcSrc;
  logic            flush;
  logic            stall;
  logic            bubble;
  logic            brTaken;
  logic            C_reg;
  logic            Z_reg;
  logic [CNTW-1:0] br_total;
  logic [CNTW-1:0] br_taken;

  modport slave (
    input  id_valid, id_opCode, ex_flagWr, alu_Cout, alu_Zout,
    output pcSrc, flush, stall, bubble, brTaken, C_reg, Z_reg, br_total, br_taken
  );

  modport master (
    output id_valid, id_opCode, ex_flagWr, alu_Cout, alu_Zout,
    input  pcSrc, flush, stall, bubble, brTaken, C_reg, Z_reg, br_total, br_taken
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Resolves conditional branches in ID against the architectural C/Z flags,
// stalls one cycle on a flag hazard and flushes IF/ID after taken branches.
//
//   state | meaning
//   RUN   | normal issue; branches resolve in their ID cycle
//   HOLD  | one-cycle stall while EX writes the flags the branch needs
//   FLUSH | extra flush cycles after a taken branch; ID contents ignored
module branch_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNTW         = 16
) (
  input logic                 clk,
  input logic                 rst,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            c_q, z_q;
  logic [CNTW-1:0] tot_q, tkn_q;

  logic is_br;
  logic cond;
  logic resolve;
  logic pc_src, flush, stall, bubble, br_taken;

  assign is_br = bus.id_valid & (bus.id_opCode[4:2] == 3'b101);

  always_comb begin
    cond = 1'b0;
    unique case (bus.id_opCode[1:0])
      2'b00: cond = z_q;
      2'b01: cond = ~z_q;
      2'b10: cond = c_q;
      2'b11: cond = ~c_q;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resolve  = 1'b0;
    pc_src   = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    bubble   = 1'b0;
    br_taken = 1'b0;

    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (is_br && bus.ex_flagWr) begin
            stall   = 1'b1;
            bubble  = 1'b1;
            state_d = HOLD;
          end else begin
            resolve = is_br;
          end
        end
        HOLD: begin
          // EX now holds the bubble, so the flags are settled
          resolve = is_br;
          state_d = RUN;
        end
        FLUSH: begin
          flush = 1'b1;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase

      if (resolve) begin
        br_taken = cond;
        pc_src   = cond;
        flush    = cond;
        if (cond && (FLUSH_CYCLES > 1)) begin
          cnt_d   = 3'(FLUSH_CYCLES - 1);
          state_d = FLUSH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      tot_q   <= '0;
      tkn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.ex_flagWr) begin
        c_q <= bus.alu_Cout;
        z_q <= bus.alu_Zout;
      end
      if (resolve) begin
        tot_q <= tot_q + 1'b1;
        if (cond) tkn_q <= tkn_q + 1'b1;
      end
    end
  end

  assign bus.pcSrc    = pc_src;
  assign bus.flush    = flush;
  assign bus.stall    = stall;
  assign bus.bubble   = bubble;
  assign bus.brTaken  = br_taken;
  assign bus.C_reg    = c_q;
  assign bus.Z_reg    = z_q;
  assign bus.br_total = tot_q;
  assign bus.br_taken = tkn_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: four configurations driven in lockstep,
// each checked every cycle against a cycle-count model of the branch rules.
module tb_branch_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_opCode;
  logic       ex_flagWr;
  logic       alu_Cout;
  logic       alu_Zout;

  always #5 clk = ~clk;

  // {pcSrc, flush, stall, bubble, brTaken, C_reg, Z_reg}
  logic [6:0]  act_ctl [4];
  logic [15:0] act_tot [4];
  logic [15:0] act_tkn [4];

  int fc_of [4] = '{1, 2, 3, 1};
  int cw_of [4] = '{16, 16, 16, 4};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int FC = (g == 1) ? 2 : (g == 2) ? 3 : 1;
    localparam int CW = (g == 3) ? 4 : 16;

    branch_hazard_ctrl_if #(.CNTW(CW)) bus ();

    assign bus.id_valid  = id_valid;
    assign bus.id_opCode = id_opCode;
    assign bus.ex_flagWr = ex_flagWr;
    assign bus.alu_Cout  = alu_Cout;
    assign bus.alu_Zout  = alu_Zout;

    branch_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNTW(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    assign act_ctl[g] = {bus.pcSrc, bus.flush, bus.stall, bus.bubble,
                         bus.brTaken, bus.C_reg, bus.Z_reg};
    assign act_tot[g] = 16'(bus.br_total);
    assign act_tkn[g] = 16'(bus.br_taken);
  end

  // Model: flags, "branch already stalled once", remaining flush cycles, counts
  int m_c [4];
  int m_z [4];
  int m_held [4];
  int m_flush_left [4];
  int m_tot [4];
  int m_tkn [4];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [4:0] op,
                      input logic fw, input logic c, input logic z);
    logic [6:0] e;
    bit         br;
    bit         cond;
    int         mask;
    @(negedge clk);
    rst = r; id_valid = v; id_opCode = op; ex_flagWr = fw; alu_Cout = c; alu_Zout = z;
    #1;
    for (int i = 0; i < 4; i++) begin
      br = v && (op[4:2] == 3'b101);
      case (op[1:0])
        2'd0:    cond = (m_z[i] != 0);
        2'd1:    cond = (m_z[i] == 0);
        2'd2:    cond = (m_c[i] != 0);
        default: cond = (m_c[i] == 0);
      endcase
      mask = (1 << cw_of[i]) - 1;
      e = {5'b0, 1'(m_c[i]), 1'(m_z[i])};

      if (r) begin
        if (m_flush_left[i] > 0) begin
          e[5] = 1'b1;
        end else if (br && m_held[i] == 0 && fw) begin
          e[4] = 1'b1;
          e[3] = 1'b1;
        end else if (br) begin
          e[6] = cond;
          e[5] = cond;
          e[2] = cond;
        end
      end

      chk($sformatf("ctl[%0d]", i), 32'(act_ctl[i]), 32'(e));
      chk($sformatf("br_total[%0d]", i), 32'(act_tot[i]), 32'(m_tot[i]));
      chk($sformatf("br_taken[%0d]", i), 32'(act_tkn[i]), 32'(m_tkn[i]));

      if (!r) begin
        m_c[i] = 0; m_z[i] = 0; m_held[i] = 0; m_flush_left[i] = 0;
        m_tot[i] = 0; m_tkn[i] = 0;
      end else begin
        if (m_flush_left[i] > 0) begin
          m_flush_left[i]--;
        end else if (br && m_held[i] == 0 && fw) begin
          m_held[i] = 1;
        end else begin
          m_held[i] = 0;
          if (br) begin
            m_tot[i] = (m_tot[i] + 1) & mask;
            if (cond) begin
              m_tkn[i] = (m_tkn[i] + 1) & mask;
              m_flush_left[i] = fc_of[i] - 1;
            end
          end
        end
        if (fw) begin
          m_c[i] = int'(c);
          m_z[i] = int'(z);
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] f;
    logic [1:0] o;
    rst = 1'b0; id_valid = 1'b0; id_opCode = '0; ex_flagWr = 1'b0;
    alu_Cout = 1'b0; alu_Zout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_c[i] = 0; m_z[i] = 0; m_held[i] = 0; m_flush_left[i] = 0;
      m_tot[i] = 0; m_tkn[i] = 0;
    end
    repeat (2) @(posedge clk);

    idle();
    chk("reset_ctl", 32'(act_ctl[2]), 32'h0);
    chk("reset_tot", 32'(act_tot[2]), 32'h0);

    // No-hazard taken branch, Z_reg=1
    step(1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    chk("taken_same_cycle", 32'(act_ctl[0]), 32'b1100101);
    idle();
    chk("taken_flush_drop", 32'(act_ctl[0]), 32'b0000001);
    chk("taken_tot", 32'(act_tot[0]), 32'd1);
    chk("taken_tkn", 32'(act_tkn[0]), 32'd1);
    chk("fc2_second_flush", 32'(act_ctl[1]), 32'b0100001);
    idle();
    chk("fc3_third_flush", 32'(act_ctl[2]), 32'b0100001);

    // Flag hazard: branch on ~Z while EX writes Z=1
    step(1'b1, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'b10101, 1'b1, 1'b0, 1'b1);
    chk("hazard_stall", 32'(act_ctl[0]), 32'b0011000);
    step(1'b1, 1'b1, 5'b10101, 1'b0, 1'b0, 1'b0);
    chk("hazard_resolve", 32'(act_ctl[0]), 32'b0000001);
    step(1'b1, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1);
    chk("hazard_tot", 32'(act_tot[0]), 32'd2);
    chk("hazard_tkn", 32'(act_tkn[0]), 32'd1);

    // Multi-cycle flush: branch during flush is ignored
    step(1'b1, 1'b1, 5'b10110, 1'b0, 1'b0, 1'b0);
    chk("c_taken", 32'(act_ctl[0]), 32'b1100111);
    step(1'b1, 1'b1, 5'b10111, 1'b0, 1'b0, 1'b0);
    chk("flush_ignores_br", 32'(act_ctl[1]), 32'b0100011);
    idle();
    chk("flush_tot_fc2", 32'(act_tot[1]), 32'd3);
    chk("flush_tot_fc1", 32'(act_tot[0]), 32'd4);

    // Non-branch filtering
    step(1'b1, 1'b1, 5'b10000, 1'b0, 1'b0, 1'b0);
    chk("nonbr_op", 32'(act_ctl[0]), 32'b0000011);
    step(1'b1, 1'b0, 5'b10100, 1'b0, 1'b0, 1'b0);
    chk("nonbr_invalid", 32'(act_ctl[0]), 32'b0000011);
    chk("nonbr_tot", 32'(act_tot[0]), 32'd4);

    // Reset on second flush cycle
    step(1'b1, 1'b1, 5'b10110, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'b10110, 1'b0, 1'b0, 1'b0);
    chk("rst_gates_ctl", 32'(act_ctl[2]), 32'b0000011);
    idle();
    chk("rst_mid_flush_ctl", 32'(act_ctl[2]), 32'h0);
    chk("rst_mid_flush_tot", 32'(act_tot[2]), 32'h0);
    chk("rst_mid_flush_tkn", 32'(act_tkn[2]), 32'h0);

    // Reset during the hold cycle
    step(1'b1, 1'b1, 5'b10100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    idle();
    chk("rst_mid_hold_ctl", 32'(act_ctl[0]), 32'h0);
    step(1'b1, 1'b1, 5'b10100, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'b10100, 1'b0, 1'b0, 1'b0);
    idle();

    // Condition table: every opcode under every flag combination
    for (int fi = 0; fi < 4; fi++) begin
      f = 2'(fi);
      step(1'b1, 1'b0, 5'b00000, 1'b1, f[1], f[0]);
      for (int oi = 0; oi < 4; oi++) begin
        o = 2'(oi);
        step(1'b1, 1'b1, {3'b101, o}, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
      end
    end

    // Counter wrap: 16 taken branches on ~Z with Z=0
    step(1'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 5'b10101, 1'b0, 1'b0, 1'b0);
    idle();
    chk("wrap_tot", 32'(act_tot[3]), 32'h0);
    chk("wrap_tkn", 32'(act_tkn[3]), 32'h0);
    chk("nowrap_tot", 32'(act_tot[0]), 32'd16);
    chk("nowrap_tkn", 32'(act_tkn[0]), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
